// File: rtl/hs32_wbm_defs.sv
// Shared definitions for the dev_wbm Wishbone master bridge:
// CPU register offsets, CTRL/STAT bit positions, FSM state encodings
// and the latched control-field struct.
package hs32_wbm_defs;

    // CPU register offsets
    localparam logic [1:0] REG_ADR  = 2'd0;
    localparam logic [1:0] REG_DTW  = 2'd1;
    localparam logic [1:0] REG_DTR  = 2'd2;
    localparam logic [1:0] REG_CTRL = 2'd3;

    // CTRL/STAT bit positions
    localparam int CTRL_GO     = 0;
    localparam int CTRL_WE     = 1;
    localparam int CTRL_SEL_LO = 2;
    localparam int CTRL_SEL_HI = 5;
    localparam int CTRL_IE     = 6;
    localparam int STAT_BUSY   = 8;
    localparam int STAT_DONE   = 9;
    localparam int STAT_TOUT   = 10;

    // FSM state encodings
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    // Field order matches CTRL bits 6:1 so a slice of the write data can
    // be cast straight into the struct.
    typedef struct packed {
        logic       ie;
        logic [3:0] sel;
        logic       we;
    } ctrl_t;

    // Assemble the CTRL/STAT read word; GO and undefined bits read 0.
    function automatic logic [31:0] stat_word(ctrl_t c, logic busy,
                                              logic done, logic tout);
        logic [31:0] w;
        w = '0;
        w[CTRL_WE]                     = c.we;
        w[CTRL_SEL_HI:CTRL_SEL_LO]     = c.sel;
        w[CTRL_IE]                     = c.ie;
        w[STAT_BUSY]                   = busy;
        w[STAT_DONE]                   = done;
        w[STAT_TOUT]                   = tout;
        return w;
    endfunction

endpackage

// File: rtl/dev_wbm_timeout.sv
// Transfer timeout counter.
//   clk, reset : clock, async active-high reset
//   clr        : clear the count (transfer launch)
//   inc        : one active cycle elapsed without an acknowledge
//   expire     : this inc is the TIMEOUT_CYCLES-th one; abort the transfer
module dev_wbm_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic expire
);

    localparam logic [15:0] LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] cnt;

    // Expire is flagged on the cycle whose increment would reach the limit,
    // so the bus cycle lasts exactly TIMEOUT_CYCLES clocks.
    assign expire = inc && (cnt == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc)
            cnt <= cnt + 16'd1;
    end

endmodule

// File: rtl/dev_wbm.sv
// CPU-programmed single-transfer Wishbone master.
//   clk, reset        : clock, async active-high reset
//   stb, we, addr, dtw: CPU register bus (write = stb && we)
//   dtr, ack          : CPU read data (combinational from addr), ack tied 1
//   wb_*              : Wishbone master port
//   intrq             : level interrupt, IE && DONE
module dev_wbm
    import hs32_wbm_defs::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stb,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] dtw,
    output logic [31:0] dtr,
    output logic        ack,
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_we,
    output logic [3:0]  wb_sel,
    output logic [31:0] wb_adr,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack,
    output logic        intrq
);

    logic [0:0]  state;
    logic [31:0] adr_r;
    logic [31:0] dtw_r;
    logic [31:0] dtr_r;
    ctrl_t       ctrl_r;
    logic        done_r;
    logic        tout_r;

    logic busy;
    logic cpu_wr;
    logic ctrl_wr;
    logic go;
    logic ack_hit;
    logic tmo_inc;
    logic tmo_exp;

    assign busy    = (state == ST_ACTIVE);
    assign cpu_wr  = stb && we;
    assign ctrl_wr = cpu_wr && (addr == REG_CTRL);
    assign go      = ctrl_wr && dtw[CTRL_GO] && !busy;
    // wb_ack only counts while a cycle is on the bus; stray acks are dropped.
    assign ack_hit = busy && wb_ack;
    assign tmo_inc = busy && !wb_ack;

    dev_wbm_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clr    (go),
        .inc    (tmo_inc),
        .expire (tmo_exp)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            adr_r  <= '0;
            dtw_r  <= '0;
            dtr_r  <= '0;
            ctrl_r <= '0;
            done_r <= 1'b0;
            tout_r <= 1'b0;
        end else begin
            // Programming registers are frozen while a transfer is in flight.
            if (cpu_wr && !busy) begin
                case (addr)
                    REG_ADR:  adr_r  <= dtw;
                    REG_DTW:  dtw_r  <= dtw;
                    REG_CTRL: ctrl_r <= ctrl_t'(dtw[CTRL_IE:CTRL_WE]);
                    default:  ;
                endcase
            end

            if (ctrl_wr && dtw[STAT_DONE])
                done_r <= 1'b0;

            if (go) begin
                state  <= ST_ACTIVE;
                done_r <= 1'b0;
                tout_r <= 1'b0;
            end

            // Completion is last so it overrides a same-cycle DONE clear,
            // and ack takes priority over a coincident timeout.
            if (ack_hit) begin
                state  <= ST_IDLE;
                done_r <= 1'b1;
                tout_r <= 1'b0;
                if (!ctrl_r.we)
                    dtr_r <= wb_dat_i;
            end else if (tmo_exp) begin
                state  <= ST_IDLE;
                done_r <= 1'b1;
                tout_r <= 1'b1;
            end
        end
    end

    always_comb begin
        dtr = '0;
        case (addr)
            REG_ADR:  dtr = adr_r;
            REG_DTW:  dtr = dtw_r;
            REG_DTR:  dtr = dtr_r;
            REG_CTRL: dtr = stat_word(ctrl_r, busy, done_r, tout_r);
            default:  dtr = '0;
        endcase
    end

    assign ack      = 1'b1;
    assign wb_cyc   = busy;
    assign wb_stb   = busy;
    assign wb_we    = busy && ctrl_r.we;
    assign wb_sel   = busy ? ctrl_r.sel : 4'h0;
    assign wb_adr   = adr_r;
    assign wb_dat_o = dtw_r;
    assign intrq    = ctrl_r.ie && done_r;

endmodule
